// File: rtl/genius_pkg.sv
// genius_pkg: shared Genius types, tempo tables and colour decode.
package genius_pkg;
  localparam int MAX_LEN = 32;
  typedef enum logic [2:0] {IDLE, FETCH0, FETCH1, SHOW, GAP, FIN} state_t;
  typedef logic [1:0] colour_t;
  localparam logic [3:0][3:0] ON_TICKS = {4'd2, 4'd4, 4'd6, 4'd8};
  localparam logic [3:0][3:0] OFF_TICKS = {4'd1, 4'd2, 4'd3, 4'd4};
  function automatic logic [3:0] onehot(colour_t c);
    return 4'b0001 << c;
  endfunction
endpackage

// File: rtl/seq_player_if.sv
// seq_player_if: control, memory and display signals of seq_player; BUZZ only with SEQ_PLAYER_SOUND_EN.
interface seq_player_if #(parameter int AW = $clog2(genius_pkg::MAX_LEN));
  logic START;
  logic [1:0] SETUP;
  logic [AW:0] ROUND;
  logic [AW-1:0] MEM_ADDR;
  logic [1:0] MEM_DATA;
  logic [3:0] LED;
  logic BUSY;
  logic DONE;
`ifdef SEQ_PLAYER_SOUND_EN
  logic BUZZ;
  modport master (output START, SETUP, ROUND, MEM_DATA, input MEM_ADDR, LED, BUSY, DONE, BUZZ);
  modport slave (input START, SETUP, ROUND, MEM_DATA, output MEM_ADDR, LED, BUSY, DONE, BUZZ);
`else
  modport master (output START, SETUP, ROUND, MEM_DATA, input MEM_ADDR, LED, BUSY, DONE);
  modport slave (input START, SETUP, ROUND, MEM_DATA, output MEM_ADDR, LED, BUSY, DONE);
`endif
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: one-cycle TICK every TICK_DIV cycles, restarted by CLR.
module tick_prescaler #(parameter int TICK_DIV = 12_500_000) (
  input logic CLK,
  input logic R,
  input logic CLR,
  output logic TICK
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] cnt;
  assign TICK = cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge CLK or negedge R)
    if (!R) cnt <= '0;
    else cnt <= (CLR || TICK) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/seq_player.sv
// seq_player: plays the stored colour sequence on the LEDs at the latched tempo.
// Defining SEQ_PLAYER_SOUND_EN adds a per-colour square-wave BUZZ during SHOW.
module seq_player #(
  parameter int TICK_DIV = 12_500_000,
  parameter int MAX_LEN = genius_pkg::MAX_LEN
) (
  input logic CLK,
  input logic R,
  seq_player_if.slave bus
);
  import genius_pkg::*;
  localparam int AW = $clog2(MAX_LEN);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(MAX_LEN);
  state_t state, state_n;
  logic [AW-1:0] idx;
  logic [1:0] lvl;
  logic [AW:0] len;
  colour_t colour;
  logic [3:0] tcnt, led;
  logic tick, clr, tdone, last, busy, done;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (.CLK(CLK), .R(R), .CLR(clr), .TICK(tick));
  assign clr = state_n != state;
  assign tdone = tick && tcnt == (state == SHOW ? ON_TICKS[lvl] : OFF_TICKS[lvl]) - 4'd1;
  assign last = {1'b0, idx} == len - 1'b1;
  assign bus.MEM_ADDR = idx;
  assign bus.LED = led;
  assign bus.BUSY = busy;
  assign bus.DONE = done;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (bus.START) state_n = bus.ROUND == '0 ? FIN : FETCH0;
      FETCH0: state_n = FETCH1;
      FETCH1: state_n = SHOW;
      SHOW: if (tdone) state_n = GAP;
      GAP: if (tdone) state_n = last ? FIN : FETCH0;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge R)
    if (!R) begin
      state <= IDLE;
      idx <= '0;
      lvl <= '0;
      len <= '0;
      colour <= '0;
      tcnt <= '0;
      led <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      tcnt <= clr ? '0 : tcnt + 4'(tick);
      if (state == IDLE && bus.START) begin
        lvl <= bus.SETUP;
        len <= bus.ROUND > LEN_MAX ? LEN_MAX : bus.ROUND;
        idx <= '0;
      end
      if (state == GAP && state_n == FETCH0) idx <= idx + 1'b1;
      if (state == FETCH1) colour <= bus.MEM_DATA;
      // colour register is still loading on the SHOW entry edge, so decode the memory word directly
      led <= state_n == SHOW ? onehot(state == FETCH1 ? bus.MEM_DATA : colour) : '0;
      busy <= state_n inside {FETCH0, FETCH1, SHOW, GAP};
      done <= state_n == FIN;
    end
`ifdef SEQ_PLAYER_SOUND_EN
  localparam int TONE_UNIT = TICK_DIV / 16 > 0 ? TICK_DIV / 16 : 1;
  localparam int TW = $clog2(5 * TONE_UNIT + 1);
  logic [TW-1:0] tone, half;
  logic buzz;
  assign half = TW'((int'(colour) + 2) * TONE_UNIT);
  assign bus.BUZZ = buzz;
  always_ff @(posedge CLK or negedge R)
    if (!R) begin
      tone <= '0;
      buzz <= 1'b0;
    end else if (state_n != SHOW) begin
      tone <= '0;
      buzz <= 1'b0;
    end else if (state != SHOW) begin
      tone <= '0;
      buzz <= 1'b1;
    end else if (tone == half - 1'b1) begin
      tone <= '0;
      buzz <= ~buzz;
    end else tone <= tone + 1'b1;
`endif
endmodule

// File: tb/tb_seq_player.sv
// tb_seq_player: table-driven and randomized playback checks against a cycle-indexed reference model.
module tb_seq_player;
  localparam int TD = 4;
  localparam int ML = 32;
  localparam int AW = 5;
  typedef struct {int lvl; int round; int done_at; bit disturb;} vec_t;
  logic clk = 1'b0;
  logic r = 1'b0;
  logic [1:0] mem [ML];
  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl [7];
  always #5 clk = ~clk;
  seq_player_if #(.AW(AW)) bus ();
  seq_player #(.TICK_DIV(TD), .MAX_LEN(ML)) dut (.CLK(clk), .R(r), .bus(bus));
  always @(posedge clk) bus.MEM_DATA <= mem[bus.MEM_ADDR];
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // expected outputs c cycles after the first FETCH0 of a play of n elements at level lvl
  task automatic model(input int lvl, input int n, input int c, output int led, output int busy,
                       output int done, output int addr, output int buzz);
    int per, on, e, o, tu;
    bit lit;
    per = 2 + (12 - 3 * lvl) * TD;
    on = (8 - 2 * lvl) * TD;
    tu = TD / 16 > 0 ? TD / 16 : 1;
    if (c < n * per) begin
      e = c / per;
      o = c % per;
      lit = o >= 2 && o < 2 + on;
      addr = e;
      busy = 1;
      done = 0;
      led = lit ? (1 << mem[e]) : 0;
      buzz = lit ? int'(((o - 2) / ((int'(mem[e]) + 2) * tu)) % 2 == 0) : 0;
    end else begin
      addr = n > 0 ? n - 1 : 0;
      busy = 0;
      done = int'(c == n * per);
      led = 0;
      buzz = 0;
    end
  endtask
  task automatic play(input int lvl, input int round, input int exp_done, input bit disturb, input string tag);
    int n, per, dc, ndone, eled, ebusy, edone, eaddr, ebuzz;
    n = round > ML ? ML : round;
    per = 2 + (12 - 3 * lvl) * TD;
    dc = -1;
    ndone = 0;
    @(negedge clk);
    bus.SETUP = 2'(lvl);
    bus.ROUND = 6'(round);
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    for (int c = 0; c <= n * per + 3; c++) begin
      model(lvl, n, c, eled, ebusy, edone, eaddr, ebuzz);
      chk({tag, " led"}, int'(bus.LED), eled);
      chk({tag, " busy"}, int'(bus.BUSY), ebusy);
      chk({tag, " done"}, int'(bus.DONE), edone);
      chk({tag, " addr"}, int'(bus.MEM_ADDR), eaddr);
`ifdef SEQ_PLAYER_SOUND_EN
      chk({tag, " buzz"}, int'(bus.BUZZ), ebuzz);
`endif
      if (bus.DONE) begin
        ndone++;
        if (dc < 0) dc = c;
      end
      if (disturb && c == per + 5) begin
        bus.SETUP = 2'd3;
        bus.ROUND = 6'd1;
        bus.START = 1'b1;
      end
      if (disturb && c == per + 6) bus.START = 1'b0;
      if (c == n * per) bus.START = 1'b1;
      if (c == n * per + 1) bus.START = 1'b0;
      @(negedge clk);
    end
    chk({tag, " done cycle"}, dc, exp_done);
    chk({tag, " done count"}, ndone, 1);
  endtask
  initial begin
    int lvl, round, nd;
    bus.START = 1'b0;
    bus.SETUP = 2'd0;
    bus.ROUND = '0;
    foreach (mem[i]) mem[i] = 2'($urandom);
    mem[0] = 2'd2;
    mem[1] = 2'd0;
    mem[2] = 2'd3;
    tbl[0] = '{0, 3, 150, 1'b0};
    tbl[1] = '{3, 1, 14, 1'b0};
    tbl[2] = '{0, 0, 0, 1'b0};
    tbl[3] = '{0, 3, 150, 1'b1};
    tbl[4] = '{1, 2, 76, 1'b0};
    tbl[5] = '{2, 3, 78, 1'b0};
    tbl[6] = '{3, 40, 448, 1'b0};
    repeat (3) @(negedge clk);
    chk("reset led", int'(bus.LED), 0);
    chk("reset busy", int'(bus.BUSY), 0);
    chk("reset done", int'(bus.DONE), 0);
    chk("reset addr", int'(bus.MEM_ADDR), 0);
    r = 1'b1;
    for (int i = 0; i < 7; i++)
      play(tbl[i].lvl, tbl[i].round, tbl[i].done_at, tbl[i].disturb, $sformatf("vec%0d", i));
    // reset during the second SHOW of a level-0 play
    @(negedge clk);
    bus.SETUP = 2'd0;
    bus.ROUND = 6'd3;
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    repeat (57) @(negedge clk);
    chk("midreset led before", int'(bus.LED), 1);
    r = 1'b0;
    #1;
    chk("midreset led", int'(bus.LED), 0);
    chk("midreset busy", int'(bus.BUSY), 0);
    chk("midreset addr", int'(bus.MEM_ADDR), 0);
    @(negedge clk);
    r = 1'b1;
    nd = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.DONE) nd++;
    end
    chk("midreset no done", nd, 0);
    play(0, 3, 150, 1'b0, "replay");
    for (int k = 0; k < 6; k++) begin
      foreach (mem[i]) mem[i] = 2'($urandom);
      lvl = int'($urandom_range(0, 3));
      round = int'($urandom_range(0, 10));
      play(lvl, round, round * (2 + (12 - 3 * lvl) * TD), 1'b0, $sformatf("rand%0d", k));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
